// File: rtl/config_load_pkg.sv
// Shared types and defaults for the tile configuration-load controllers.
// Holds the sequencer state encoding, default geometry and a one-hot helper.
package config_load_pkg;

    localparam int DEF_NUM_WORDS = 21;
    localparam int DEF_WORD_W    = 32;
    localparam int DEF_IDX_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        STROBE,
        HOLD,
        DONE,
        CHECK
    } cfg_state_e;

    // Slice enable for the default geometry; indices past the last slice give all-zero.
    function automatic logic [DEF_NUM_WORDS-1:0] onehot(input logic [DEF_IDX_W-1:0] idx);
        logic [DEF_NUM_WORDS-1:0] v;
        v = '0;
        if (int'(idx) < DEF_NUM_WORDS) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/config_onehot_dec.sv
// Index-to-one-hot decoder with a global enable, shared by the tile config controllers.
// Indices at or beyond NUM_OUT decode to all-zero so no stray slice can open.
module config_onehot_dec #(
    parameter int IDX_W   = 5,
    parameter int NUM_OUT = 21
) (
    input  logic               en_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [NUM_OUT-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (en_i && (idx_i == IDX_W'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/config_load_ctrl.sv
// Streams NUM_WORDS config words into the transparent-latch store: register, strobe, hold.
// Optional trailing XOR checksum word is enabled by defining CONFIG_LOAD_CHECKSUM_EN.
module config_load_ctrl
    import config_load_pkg::*;
#(
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_abort,
    input  logic                 io_word_valid,
    input  logic [WORD_W-1:0]    io_word_in,
    output logic                 io_word_ready,
    output logic [WORD_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic                 io_done,
    output logic                 io_error
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    cfg_state_e             state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [WORD_W-1:0]      d_out_q;
    logic [NUM_WORDS-1:0]   en_q;
    logic [NUM_WORDS-1:0]   en_d;
    logic                   ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   in_seq;
    logic                   abort_act;
    logic                   accept_w;
`ifdef CONFIG_LOAD_CHECKSUM_EN
    logic [WORD_W-1:0]      xor_q;
    logic                   error_q;
`endif

`ifdef CONFIG_LOAD_CHECKSUM_EN
    assign in_seq = (state_q == WAIT) || (state_q == STROBE) ||
                    (state_q == HOLD) || (state_q == CHECK);
`else
    assign in_seq = (state_q == WAIT) || (state_q == STROBE) || (state_q == HOLD);
`endif

    assign abort_act = io_abort && in_seq;
    // Abort beats a same-cycle transfer, so the word is dropped and no pulse follows.
    assign accept_w  = (state_q == WAIT) && io_word_valid && !io_abort;

    config_onehot_dec #(
        .IDX_W   (IDX_W),
        .NUM_OUT (NUM_WORDS)
    ) u_dec (
        .en_i     (accept_w),
        .idx_i    (idx_q),
        .onehot_o (en_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            d_out_q <= '0;
            en_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CONFIG_LOAD_CHECKSUM_EN
            xor_q   <= '0;
            error_q <= 1'b0;
`endif
        end else if (abort_act) begin
            // Data is left alone: latches are already closed and written slices stay written.
            state_q <= IDLE;
            idx_q   <= '0;
            en_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            en_q <= en_d;
            case (state_q)
                IDLE, DONE: begin
                    if (io_start && io_abort) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end else if (io_start) begin
                        state_q <= WAIT;
                        idx_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef CONFIG_LOAD_CHECKSUM_EN
                        xor_q   <= '0;
                        error_q <= 1'b0;
`endif
                    end
                end
                WAIT: begin
                    if (io_word_valid) begin
                        state_q <= STROBE;
                        d_out_q <= io_word_in;
                        ready_q <= 1'b0;
`ifdef CONFIG_LOAD_CHECKSUM_EN
                        xor_q   <= xor_q ^ io_word_in;
`endif
                    end
                end
                STROBE: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (idx_q == LAST_IDX) begin
`ifdef CONFIG_LOAD_CHECKSUM_EN
                        state_q <= CHECK;
                        ready_q <= 1'b1;
`else
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= WAIT;
                        idx_q   <= idx_q + 1'b1;
                        ready_q <= 1'b1;
                    end
                end
`ifdef CONFIG_LOAD_CHECKSUM_EN
                CHECK: begin
                    if (io_word_valid) begin
                        state_q <= DONE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        error_q <= (io_word_in != xor_q);
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    en_q    <= '0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign io_word_ready = ready_q;
    assign io_d_out      = d_out_q;
    assign io_configs_en = en_q;
    assign io_busy       = busy_q;
    assign io_done       = done_q;
`ifdef CONFIG_LOAD_CHECKSUM_EN
    assign io_error      = error_q;
`else
    assign io_error      = 1'b0;
`endif

endmodule
